// File: rtl/bus_glue.sv
// bus_glue: 68000 bus-cycle controller. Decodes each CPU cycle into ROM, RAM
// or IO, drives the matching chip select, inserts per-region wait states and
// terminates the cycle with DTACK, BERR (unmapped, ROM write, watchdog) or
// VPA (interrupt-acknowledge autovector). All outputs are registered.
module bus_glue #(
  parameter int ROM_WAIT = 1,
  parameter int RAM_WAIT = 0,
  parameter int IO_WAIT  = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        as_n,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic        read,
  input  logic [2:0]  fc,
  input  logic [23:0] addr,
  input  logic        io_ready_n,
  output logic        dtack_n,
  output logic        berr_n,
  output logic        vpa_n,
  output logic        rom_cs_n,
  output logic        ram_cs_n,
  output logic        io_cs_n,
  output logic [2:0]  state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_ACK   = 3'd2;
  localparam logic [2:0] ST_FAULT = 3'd3;
  localparam logic [2:0] ST_AVEC  = 3'd4;

  localparam logic [1:0] R_ROM  = 2'd0;
  localparam logic [1:0] R_RAM  = 2'd1;
  localparam logic [1:0] R_IO   = 2'd2;
  localparam logic [1:0] R_NONE = 2'd3;

  // Counters only need to reach TIMEOUT; every wait value is below it.
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wcnt, wcnt_nx;
  logic [CW-1:0] wdog, wdog_nx;
  logic [1:0]    region, region_nx;
  logic          cs_en, cs_en_nx;
  logic [2:0]    state_nx;
  logic          dtack_nx, berr_nx, vpa_nx;
  logic          rom_cs_nx, ram_cs_nx, io_cs_nx;
  logic          cs_act;
  logic [1:0]    dec_region;

  // Only the top two address bits take part in the region decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[21:0];

  assign dec_region = addr[23:22];

  function automatic logic [CW-1:0] wait_of(input logic [1:0] r);
    case (r)
      R_ROM:   return CW'(ROM_WAIT);
      R_RAM:   return CW'(RAM_WAIT);
      R_IO:    return CW'(IO_WAIT);
      default: return '0;
    endcase
  endfunction

  // Next-state, counter and termination decode for the coming edge.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_nx  = state;
    wcnt_nx   = wcnt;
    wdog_nx   = wdog;
    region_nx = region;
    cs_en_nx  = cs_en;
    dtack_nx  = 1'b1;
    berr_nx   = 1'b1;
    vpa_nx    = 1'b1;

    if (as_n) begin
      // Strobe high ends (or aborts) whatever cycle is in progress.
      state_nx = ST_IDLE;
      wcnt_nx  = '0;
      wdog_nx  = '0;
      cs_en_nx = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          region_nx = dec_region;
          wdog_nx   = '0;
          if (fc == 3'b111) begin
            state_nx = ST_AVEC;
            vpa_nx   = 1'b0;
            cs_en_nx = 1'b0;
          end else if (dec_region == R_NONE || (dec_region == R_ROM && !read)) begin
            state_nx = ST_FAULT;
            berr_nx  = 1'b0;
            cs_en_nx = 1'b0;
          end else begin
            cs_en_nx = 1'b1;
            wcnt_nx  = wait_of(dec_region);
            if (wcnt_nx == '0 && (dec_region != R_IO || !io_ready_n)) begin
              state_nx = ST_ACK;
              dtack_nx = 1'b0;
            end else begin
              state_nx = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          wcnt_nx = (wcnt == '0) ? '0 : wcnt - 1'b1;
          wdog_nx = wdog + 1'b1;
          if (wcnt_nx == '0 && (region != R_IO || !io_ready_n)) begin
            state_nx = ST_ACK;
            dtack_nx = 1'b0;
          end else if (wdog_nx == CW'(TIMEOUT)) begin
            // Chip select deliberately stays asserted on a watchdog fault.
            state_nx = ST_FAULT;
            berr_nx  = 1'b0;
          end
        end
        ST_ACK:   dtack_nx = 1'b0;
        ST_FAULT: berr_nx  = 1'b0;
        ST_AVEC:  vpa_nx   = 1'b0;
        default: begin
          state_nx = ST_IDLE;
          cs_en_nx = 1'b0;
        end
      endcase
    end

    // ROM ignores the data strobes; RAM and IO need at least one active.
    cs_act    = !as_n && cs_en_nx && (region_nx == R_ROM || !(uds_n && lds_n));
    rom_cs_nx = !(cs_act && region_nx == R_ROM);
    ram_cs_nx = !(cs_act && region_nx == R_RAM);
    io_cs_nx  = !(cs_act && region_nx == R_IO);
  end

  // State, counters and registered outputs; reset forces the idle values at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      wcnt     <= '0;
      wdog     <= '0;
      region   <= R_NONE;
      cs_en    <= 1'b0;
      dtack_n  <= 1'b1;
      berr_n   <= 1'b1;
      vpa_n    <= 1'b1;
      rom_cs_n <= 1'b1;
      ram_cs_n <= 1'b1;
      io_cs_n  <= 1'b1;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      state    <= state_nx;
      wcnt     <= wcnt_nx;
      wdog     <= wdog_nx;
      region   <= region_nx;
      cs_en    <= cs_en_nx;
      dtack_n  <= dtack_nx;
      berr_n   <= berr_nx;
      vpa_n    <= vpa_nx;
      rom_cs_n <= rom_cs_nx;
      ram_cs_n <= ram_cs_nx;
      io_cs_n  <= io_cs_nx;
    end
  end

endmodule

// File: tb/tb_bus_glue.sv
// tb_bus_glue: directed stimulus pushes timestamped expected output vectors
// into a queue; a monitor pops one entry each time the DUT outputs change and
// compares both the value and the edge on which it appeared.
module tb_bus_glue;

  logic        clk = 1'b0;
  logic        reset;
  logic        as_n, uds_n, lds_n, read, io_ready_n;
  logic [2:0]  fc;
  logic [23:0] addr;
  logic        dtack_n, berr_n, vpa_n, rom_cs_n, ram_cs_n, io_cs_n;
  logic [2:0]  state;

  bus_glue dut (
    .clk(clk), .reset(reset), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
    .read(read), .fc(fc), .addr(addr), .io_ready_n(io_ready_n),
    .dtack_n(dtack_n), .berr_n(berr_n), .vpa_n(vpa_n),
    .rom_cs_n(rom_cs_n), .ram_cs_n(ram_cs_n), .io_cs_n(io_cs_n),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [8:0] v;
    string      name;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  logic       mon_en = 1'b0;
  logic [8:0] outs, prev;

  assign outs = {state, dtack_n, berr_n, vpa_n, rom_cs_n, ram_cs_n, io_cs_n};

  // Output vector: state, dtack, berr, vpa, rom_cs, ram_cs, io_cs.
  function automatic logic [8:0] mk(input logic [2:0] st, input logic dt,
      input logic be, input logic vp, input logic ro, input logic ra, input logic io);
    return {st, dt, be, vp, ro, ra, io};
  endfunction

  localparam logic [8:0] IDLE_V = 9'b000_111_111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_at(input int c, input logic [8:0] v, input string n);
    exp_q.push_back('{c, v, n});
  endtask

  // Begin a bus cycle; k is the first edge that samples as_n low.
  task automatic start(input logic [2:0] f, input logic [23:0] a, input logic rd,
      input logic ds_n, output int k);
    @(negedge clk);
    fc = f; addr = a; read = rd; uds_n = ds_n; lds_n = ds_n; as_n = 1'b0;
    k = cyc + 1;
  endtask

  task automatic release_cycle(input string n);
    @(negedge clk);
    as_n = 1'b1;
    expect_at(cyc + 1, IDLE_V, n);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output change must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en && outs !== prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_change", {23'b0, outs}, {23'b0, prev});
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_edge"}, cyc, e.cyc);
        check(e.name, {23'b0, outs}, {23'b0, e.v});
      end
    end
    prev = outs;
  end

  initial begin
    int k;
    reset = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; read = 1'b1;
    fc = 3'b101; addr = '0; io_ready_n = 1'b1;
    #2;
    check("reset_outputs", {23'b0, outs}, {23'b0, IDLE_V});
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(1);
    mon_en = 1'b1;

    // RAM read, zero wait: select and DTACK together at edge k.
    start(3'b101, 24'h400010, 1'b1, 1'b0, k);
    expect_at(k, mk(3'd2, 0, 1, 1, 1, 0, 1), "ram_ack");
    wait_cycles(3);
    release_cycle("ram_release");
    // Back-to-back: one edge sampled high, next edge starts a new cycle.
    start(3'b101, 24'h400020, 1'b0, 1'b0, k);
    expect_at(k, mk(3'd2, 0, 1, 1, 1, 0, 1), "ram_b2b_ack");
    wait_cycles(2);
    release_cycle("ram_b2b_release");

    // RAM with no data strobe: cycle acknowledges but chip select stays off.
    start(3'b101, 24'h400030, 1'b1, 1'b1, k);
    expect_at(k, mk(3'd2, 0, 1, 1, 1, 1, 1), "ram_nods_ack");
    wait_cycles(2);
    release_cycle("ram_nods_release");

    // ROM read, one wait state.
    start(3'b110, 24'h000100, 1'b1, 1'b1, k);
    expect_at(k,     mk(3'd1, 1, 1, 1, 0, 1, 1), "rom_wait");
    expect_at(k + 1, mk(3'd2, 0, 1, 1, 0, 1, 1), "rom_ack");
    wait_cycles(3);
    release_cycle("rom_release");

    // IO read with the device never ready: watchdog BERR at k+64, select held.
    io_ready_n = 1'b1;
    start(3'b101, 24'h800000, 1'b1, 1'b0, k);
    expect_at(k,      mk(3'd1, 1, 1, 1, 1, 1, 0), "io_to_wait");
    expect_at(k + 64, mk(3'd3, 1, 0, 1, 1, 1, 0), "io_timeout");
    wait_cycles(67);
    release_cycle("io_to_release");

    // IO read with ready sampled low first at edge k+5.
    start(3'b101, 24'h800000, 1'b1, 1'b0, k);
    expect_at(k,     mk(3'd1, 1, 1, 1, 1, 1, 0), "io_rdy_wait");
    expect_at(k + 5, mk(3'd2, 0, 1, 1, 1, 1, 0), "io_rdy_ack");
    while (cyc < k + 4) @(negedge clk);
    io_ready_n = 1'b0;
    wait_cycles(3);
    release_cycle("io_rdy_release");
    @(negedge clk);
    io_ready_n = 1'b1;

    // IO cycle aborted by as_n rising while still waiting.
    start(3'b101, 24'h800004, 1'b0, 1'b0, k);
    expect_at(k, mk(3'd1, 1, 1, 1, 1, 1, 0), "io_abort_wait");
    wait_cycles(2);
    release_cycle("io_abort_release");

    // ROM write faults immediately without a chip select.
    start(3'b101, 24'h000200, 1'b0, 1'b0, k);
    expect_at(k, mk(3'd3, 1, 0, 1, 1, 1, 1), "rom_write_fault");
    wait_cycles(2);
    release_cycle("rom_write_release");

    // Unmapped read faults the same way.
    start(3'b101, 24'hC00000, 1'b1, 1'b0, k);
    expect_at(k, mk(3'd3, 1, 0, 1, 1, 1, 1), "unmapped_fault");
    wait_cycles(2);
    release_cycle("unmapped_release");

    // Interrupt acknowledge: VPA only, even though the address is unmapped.
    start(3'b111, 24'hFFFFF5, 1'b1, 1'b0, k);
    expect_at(k, mk(3'd4, 1, 1, 0, 1, 1, 1), "iack_vpa");
    wait_cycles(2);
    release_cycle("iack_release");

    // Reset in the middle of an acknowledged RAM cycle, between clock edges.
    start(3'b101, 24'h400010, 1'b1, 1'b0, k);
    expect_at(k, mk(3'd2, 0, 1, 1, 1, 0, 1), "ram_pre_reset_ack");
    wait_cycles(2);
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_reset_dtack", {31'b0, dtack_n}, 32'd1);
    check("async_reset_ram_cs", {31'b0, ram_cs_n}, 32'd1);
    check("async_reset_state", {29'b0, state}, 32'd0);
    @(negedge clk);
    as_n = 1'b1;
    reset = 1'b0;
    wait_cycles(2);
    mon_en = 1'b1;

    wait_cycles(3);
    check("all_expectations_seen", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
